// File: rtl/osd_ram_pkg.sv
// Shared defaults and FSM state type for the OSD buffer RAM controller.
package osd_ram_pkg;

  localparam int unsigned OSD_ADDR_W = 11;
  localparam int unsigned OSD_DATA_W = 8;
  localparam int unsigned OSD_DEPTH  = 1 << OSD_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/osd_clr_engine.sv
// Clear engine: walks a wrapping pointer from base for len cycles, requesting
// one fill write per cycle, then pulses done for one cycle.
module osd_clr_engine
  import osd_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = OSD_ADDR_W,
  parameter int unsigned DATA_W = OSD_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic [DATA_W-1:0] value_i,
  output logic              idle_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              fill_req_o,
  output logic [ADDR_W-1:0] fill_addr_o,
  output logic [DATA_W-1:0] fill_data_o
);

  localparam int unsigned       CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [CNT_W-1:0]  len_clamped;
  logic              idle_q, busy_q, done_q, fill_q;

  // Lengths beyond the buffer depth would only rewrite the same addresses.
  assign len_clamped = (len_i > LEN_MAX) ? LEN_MAX : len_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && (len_i != '0)) begin
          state_d = ST_CLEAR;
          ptr_d   = base_i;
          cnt_d   = len_clamped;
          value_d = value_i;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      idle_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      idle_q  <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      fill_q  <= (state_d == ST_CLEAR);
    end
  end

  assign idle_o      = idle_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fill_req_o  = fill_q;
  assign fill_addr_o = ptr_q;
  assign fill_data_o = value_q;

endmodule

// File: rtl/osd_ram_ctrl.sv
// OSD buffer RAM controller: muxes host and clear-fill writes onto one
// registered RAM write port and runs a single-cycle read pipeline.
module osd_ram_ctrl
  import osd_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = OSD_ADDR_W,
  parameter int unsigned DATA_W = OSD_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_req_i,
  output logic              rd_ready_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_rsp_valid_o,
  output logic [DATA_W-1:0] rd_rsp_data_o,
  input  logic              clr_start_i,
  input  logic [ADDR_W-1:0] clr_base_i,
  input  logic [ADDR_W:0]   clr_len_i,
  input  logic [DATA_W-1:0] clr_value_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [DATA_W-1:0] ram_wr_data_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [DATA_W-1:0] ram_rd_data_i
);

  logic              eng_idle;
  logic              fill_req;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              host_acc;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rsp_valid_q;

  osd_clr_engine #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_clr_engine (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (clr_start_i),
    .base_i      (clr_base_i),
    .len_i       (clr_len_i),
    .value_i     (clr_value_i),
    .idle_o      (eng_idle),
    .busy_o      (clr_busy_o),
    .done_o      (clr_done_o),
    .fill_req_o  (fill_req),
    .fill_addr_o (fill_addr),
    .fill_data_o (fill_data)
  );

  assign wr_ready_o = eng_idle;
  assign host_acc   = wr_valid_i && eng_idle;

  // Host writes are only taken in IDLE and fills only occur in CLEAR, so the
  // two sources never compete; address/data hold when no write is issued.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (fill_req) begin
      wr_en_d   = 1'b1;
      wr_addr_d = fill_addr;
      wr_data_d = fill_data;
    end else if (host_acc) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wr_addr_i;
      wr_data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rd_req_i && rd_ready_o;
    end
  end

  // A read of the address being written this cycle would return stale data.
  assign rd_ready_o     = !(wr_en_q && (wr_addr_q == rd_addr_i));
  assign ram_rd_addr_o  = rd_addr_i;
  assign rd_rsp_valid_o = rsp_valid_q;
  assign rd_rsp_data_o  = ram_rd_data_i;

  assign ram_wr_en_o   = wr_en_q;
  assign ram_wr_addr_o = wr_addr_q;
  assign ram_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_osd_ram_ctrl.sv
// Scoreboard bench for osd_ram_ctrl with a behavioural 1-cycle-latency RAM.
module tb_osd_ram_ctrl;

  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 2048;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_rec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req, rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_rsp_valid;
  logic [DW-1:0] rd_rsp_data;
  logic          clr_start;
  logic [AW-1:0] clr_base;
  logic [AW:0]   clr_len;
  logic [DW-1:0] clr_value;
  logic          clr_busy, clr_done;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  wr_rec_t       wr_q[$];
  logic [DW-1:0] rd_q[$];
  int            total = 0;
  int            bad = 0;
  int            n_writes = 0;
  int            n_done = 0;

  always #5 clk = ~clk;

  osd_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready),
    .wr_addr_i      (wr_addr),
    .wr_data_i      (wr_data),
    .rd_req_i       (rd_req),
    .rd_ready_o     (rd_ready),
    .rd_addr_i      (rd_addr),
    .rd_rsp_valid_o (rd_rsp_valid),
    .rd_rsp_data_o  (rd_rsp_data),
    .clr_start_i    (clr_start),
    .clr_base_i     (clr_base),
    .clr_len_i      (clr_len),
    .clr_value_i    (clr_value),
    .clr_busy_o     (clr_busy),
    .clr_done_o     (clr_done),
    .ram_wr_en_o    (ram_wr_en),
    .ram_wr_addr_o  (ram_wr_addr),
    .ram_wr_data_o  (ram_wr_data),
    .ram_rd_addr_o  (ram_rd_addr),
    .ram_rd_data_i  (ram_rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_rec_t r;
    r.addr = a;
    r.data = d;
    wr_q.push_back(r);
    exp_mem[a] = d;
  endtask

  // Read-before-write RAM: read data captured before the same-edge write lands.
  task automatic ram_model();
    forever begin
      @(posedge clk);
      ram_rd_data = mem[ram_rd_addr];
      if (ram_wr_en === 1'b1) mem[ram_wr_addr] = ram_wr_data;
    end
  endtask

  task automatic monitor();
    wr_rec_t       e;
    logic [DW-1:0] ed;
    forever begin
      @(negedge clk);
      if (ram_wr_en === 1'b1) begin
        n_writes++;
        total++;
        if (wr_q.size() == 0) begin
          bad++;
          $display("FAIL wr_unexpected got addr=%h data=%h want none", ram_wr_addr, ram_wr_data);
        end else begin
          e = wr_q.pop_front();
          if (ram_wr_addr !== e.addr || ram_wr_data !== e.data) begin
            bad++;
            $display("FAIL wr_seq got addr=%h data=%h want addr=%h data=%h",
                     ram_wr_addr, ram_wr_data, e.addr, e.data);
          end
        end
      end
      if (rd_rsp_valid === 1'b1) begin
        total++;
        if (rd_q.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected got data=%h want none", rd_rsp_data);
        end else begin
          ed = rd_q.pop_front();
          if (rd_rsp_data !== ed) begin
            bad++;
            $display("FAIL rd_data got=%h want=%h", rd_rsp_data, ed);
          end
        end
      end
      if (clr_done === 1'b1) n_done++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ram_wr_en, ram_wr_addr, ram_wr_data, rd_rsp_valid, clr_busy, clr_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got en=%b addr=%h data=%h rv=%b busy=%b done=%b want all 0",
               ram_wr_en, ram_wr_addr, ram_wr_data, rd_rsp_valid, clr_busy, clr_done);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
    total++;
    if (rd_ready !== 1'b1) begin bad++; $display("FAIL reset_rd_ready got=%b want=1", rd_ready); end
  endtask

  task automatic test_write_read();
    tick();
    wr_valid = 1'b1; wr_addr = 11'h123; wr_data = 8'h5A;
    push_wr(11'h123, 8'h5A);
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    total++;
    if (ram_wr_en !== 1'b1 || ram_wr_addr !== 11'h123 || ram_wr_data !== 8'h5A) begin
      bad++;
      $display("FAIL host_wr_latency got en=%b addr=%h data=%h want 1/123/5a", ram_wr_en, ram_wr_addr, ram_wr_data);
    end
    tick();
    rd_req = 1'b1; rd_addr = 11'h123;
    @(negedge clk);
    total++;
    if (rd_ready !== 1'b1) begin bad++; $display("FAIL wr_rd_ready got=%b want=1", rd_ready); end
    else rd_q.push_back(8'h5A);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    total++;
    if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== 8'h5A) begin
      bad++;
      $display("FAIL rd_rsp_latency got v=%b data=%h want 1/5a", rd_rsp_valid, rd_rsp_data);
    end
  endtask

  task automatic test_collision();
    tick();
    wr_valid = 1'b1; wr_addr = 11'h010; wr_data = 8'hC3;
    push_wr(11'h010, 8'hC3);
    tick();
    wr_valid = 1'b0; rd_req = 1'b1; rd_addr = 11'h010;
    @(negedge clk);
    total++;
    if (rd_ready !== 1'b0) begin bad++; $display("FAIL collide_block got=%b want=0", rd_ready); end
    tick();
    @(negedge clk);
    total++;
    if (rd_ready !== 1'b1) begin bad++; $display("FAIL collide_release got=%b want=1", rd_ready); end
    else rd_q.push_back(8'hC3);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    total++;
    if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== 8'hC3) begin
      bad++;
      $display("FAIL collide_data got v=%b data=%h want 1/c3", rd_rsp_valid, rd_rsp_data);
    end
  endtask

  task automatic do_clear(input logic [AW-1:0] base, input logic [AW:0] len,
                          input logic [DW-1:0] val, input logic with_reads);
    int n, w0, done_cnt, done_late, busy_bad, rdy_bad, rd_bad;
    n = (len > 12'd2048) ? 2048 : int'(len);
    done_cnt = 0; done_late = 0; busy_bad = 0; rdy_bad = 0; rd_bad = 0;
    for (int k = 0; k < n; k++) push_wr(AW'(int'(base) + k), val);
    tick();
    w0 = n_writes;
    clr_start = 1'b1; clr_base = base; clr_len = len; clr_value = val;
    tick();
    clr_start = 1'b0;
    if (n == 0) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (clr_busy !== 1'b0 || clr_done !== 1'b0 || wr_ready !== 1'b1) busy_bad++;
        tick();
      end
      total++;
      if (busy_bad != 0) begin bad++; $display("FAIL clr_len0_noop got %0d bad cycles want 0", busy_bad); end
    end else begin
      if (with_reads) begin rd_req = 1'b1; rd_addr = 11'h300; end
      for (int i = 1; i <= n + 1; i++) begin
        @(negedge clk);
        if (clr_busy !== 1'b1) busy_bad++;
        if (wr_ready !== 1'b0) rdy_bad++;
        if (clr_done === 1'b1) begin
          done_cnt++;
          if (i != n + 1) done_late++;
        end
        if (with_reads) begin
          if (rd_ready !== 1'b1) rd_bad++;
          else rd_q.push_back(exp_mem[11'h300]);
        end
        tick();
      end
      rd_req = 1'b0;
      total++;
      if (busy_bad != 0) begin bad++; $display("FAIL clr_busy got %0d low cycles want 0", busy_bad); end
      total++;
      if (rdy_bad != 0) begin bad++; $display("FAIL clr_wr_ready got %0d high cycles want 0", rdy_bad); end
      total++;
      if (done_cnt != 1 || done_late != 0) begin
        bad++;
        $display("FAIL clr_done got count=%0d misplaced=%0d want 1/0", done_cnt, done_late);
      end
      if (with_reads) begin
        total++;
        if (rd_bad != 0) begin bad++; $display("FAIL clr_rd_ready got %0d blocked want 0", rd_bad); end
      end
      @(negedge clk);
      total++;
      if (clr_busy !== 1'b0 || wr_ready !== 1'b1) begin
        bad++;
        $display("FAIL clr_end got busy=%b wr_ready=%b want 0/1", clr_busy, wr_ready);
      end
    end
    total++;
    if (n_writes - w0 != n) begin bad++; $display("FAIL clr_write_count got=%0d want=%0d", n_writes - w0, n); end
  endtask

  task automatic test_clear_wrap();
    do_clear(11'h7FE, 12'd4, 8'h20, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    int rd_bad;
    rd_bad = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      a = (k == 4) ? 11'h123 : AW'(12'h7FE + k);
      rd_req = 1'b1; rd_addr = a;
      @(negedge clk);
      if (rd_ready !== 1'b1) rd_bad++;
      else rd_q.push_back(exp_mem[a]);
      tick();
    end
    rd_req = 1'b0;
    total++;
    if (rd_bad != 0) begin bad++; $display("FAIL b2b_rd_ready got %0d blocked want 0", rd_bad); end
    @(negedge clk);
    total++;
    if (rd_rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_last_rsp got=%b want=1", rd_rsp_valid); end
  endtask

  task automatic test_clear_len_edges();
    do_clear(11'h100, 12'd0, 8'h33, 1'b0);
    do_clear(11'h100, 12'd4095, 8'h44, 1'b0);
  endtask

  task automatic test_same_cycle();
    int guard;
    tick();
    wr_valid = 1'b1; wr_addr = 11'h005; wr_data = 8'h77;
    clr_start = 1'b1; clr_base = 11'h040; clr_len = 12'd3; clr_value = 8'h99;
    push_wr(11'h005, 8'h77);
    for (int k = 0; k < 3; k++) push_wr(AW'(12'h040 + k), 8'h99);
    tick();
    wr_valid = 1'b0; clr_start = 1'b0;
    @(negedge clk);
    total++;
    if (ram_wr_en !== 1'b1 || ram_wr_addr !== 11'h005 || ram_wr_data !== 8'h77) begin
      bad++;
      $display("FAIL same_host_first got en=%b addr=%h data=%h want 1/005/77", ram_wr_en, ram_wr_addr, ram_wr_data);
    end
    tick();
    @(negedge clk);
    total++;
    if (ram_wr_en !== 1'b1 || ram_wr_addr !== 11'h040 || ram_wr_data !== 8'h99) begin
      bad++;
      $display("FAIL same_fill_next got en=%b addr=%h data=%h want 1/040/99", ram_wr_en, ram_wr_addr, ram_wr_data);
    end
    guard = 0;
    while (clr_busy === 1'b1 && guard < 10) begin
      tick();
      @(negedge clk);
      guard++;
    end
    total++;
    if (clr_busy !== 1'b0) begin bad++; $display("FAIL same_finish got busy=%b want 0", clr_busy); end
  endtask

  task automatic test_reset_abort();
    int d0, rd_bad;
    logic [AW-1:0] a;
    rd_bad = 0;
    tick();
    clr_start = 1'b1; clr_base = 11'h200; clr_len = 12'd10; clr_value = 8'hEE;
    for (int k = 0; k < 3; k++) push_wr(AW'(12'h200 + k), 8'hEE);
    tick();
    clr_start = 1'b0;
    repeat (4) tick();
    total++;
    if (ram_wr_en !== 1'b1 || ram_wr_addr !== 11'h203) begin
      bad++;
      $display("FAIL abort_point got en=%b addr=%h want 1/203", ram_wr_en, ram_wr_addr);
    end
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ram_wr_en, ram_wr_addr, ram_wr_data, rd_rsp_valid, clr_busy, clr_done} !== '0) begin
      bad++;
      $display("FAIL abort_outputs got en=%b addr=%h data=%h rv=%b busy=%b done=%b want all 0",
               ram_wr_en, ram_wr_addr, ram_wr_data, rd_rsp_valid, clr_busy, clr_done);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (wr_ready !== 1'b1 || clr_busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle got wr_ready=%b busy=%b want 1/0", wr_ready, clr_busy);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      a = AW'(12'h200 + k);
      rd_req = 1'b1; rd_addr = a;
      @(negedge clk);
      if (rd_ready !== 1'b1) rd_bad++;
      else rd_q.push_back(exp_mem[a]);
    end
    tick();
    rd_req = 1'b0;
    total++;
    if (rd_bad != 0) begin bad++; $display("FAIL abort_rd_ready got %0d blocked want 0", rd_bad); end
    repeat (2) tick();
    total++;
    if (n_done != d0) begin bad++; $display("FAIL abort_done got=%0d pulses want 0", n_done - d0); end
  endtask

  initial begin
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    clr_start = 1'b0; clr_base = '0; clr_len = '0; clr_value = '0;
    ram_rd_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = 8'(i) ^ 8'hA5;
      exp_mem[i] = 8'(i) ^ 8'hA5;
    end
    fork
      ram_model();
      monitor();
    join_none
    test_reset();
    test_write_read();
    test_collision();
    test_clear_wrap();
    test_back_to_back();
    test_clear_len_edges();
    test_same_cycle();
    test_reset_abort();
    repeat (3) tick();
    total++;
    if (wr_q.size() != 0) begin bad++; $display("FAIL wr_q_drain got=%0d pending want 0", wr_q.size()); end
    total++;
    if (rd_q.size() != 0) begin bad++; $display("FAIL rd_q_drain got=%0d pending want 0", rd_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/osd_ram_ctrl.md
OSD_RAM_CTRL -- requirements
Module: osd_ram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the OSD buffer address width (depth 2^ADDR_W = 2048).
REQ-002 Parameter DATA_W, default 8, SHALL set the OSD buffer data width.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge on clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_valid / wr_ready  input / output  1 / 1  host write handshake.
REQ-006 wr_addr / wr_data  input  ADDR_W / DATA_W  host write address and byte.
REQ-007 rd_req / rd_ready  input / output  1 / 1  host read request handshake.
REQ-008 rd_addr  input  ADDR_W  host read address.
REQ-009 rd_rsp_valid / rd_rsp_data  output  1 / DATA_W  read response.
REQ-010 clr_start  input  1  single-cycle clear request.
REQ-011 clr_base / clr_len / clr_value  input  ADDR_W / ADDR_W+1 / DATA_W  clear start address, byte count, fill byte.
REQ-012 clr_busy / clr_done  output  1 / 1  clear in progress; one-cycle completion pulse.
REQ-013 ram_wr_en / ram_wr_addr / ram_wr_data  output  1 / ADDR_W / DATA_W  RAM write port drive.
REQ-014 ram_rd_addr  output ADDR_W; ram_rd_data  input DATA_W  RAM read port (1-cycle read latency, no output register).

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, DONE; IDLE->CLEAR on clr_start with clr_len != 0; CLEAR->DONE after last fill write issued; DONE->IDLE unconditionally after one cycle.
REQ-016 clr_start with clr_len == 0 SHALL be a no-op (no write, no clr_done); clr_start outside IDLE SHALL be ignored.
REQ-017 clr_len > 2^ADDR_W SHALL be clamped to 2^ADDR_W; base, length, value SHALL be latched on accepted clr_start.
REQ-018 In CLEAR, one fill write per cycle at pointer p, p starting at clr_base and incrementing modulo 2^ADDR_W (2047 wraps to 0).
REQ-019 clr_busy SHALL be high in CLEAR and DONE; clr_done SHALL be high exactly in DONE.
REQ-020 wr_ready SHALL equal (state == IDLE), combinational; a write is accepted when wr_valid && wr_ready.
REQ-021 Accepted host write at edge N SHALL appear as registered ram_wr_en/addr/data during cycle N+1; fill writes likewise registered, one per cycle.
REQ-022 clr_start and an accepted host write in the same cycle: host write SHALL be issued first (cycle N+1), first fill write in cycle N+2.
REQ-023 ram_rd_addr SHALL equal rd_addr combinationally; a read is accepted when rd_req && rd_ready.
REQ-024 rd_ready SHALL be low when ram_wr_en is high and ram_wr_addr == rd_addr (same-address collision); otherwise high, including during CLEAR.
REQ-025 rd_rsp_valid SHALL be high in the cycle after read acceptance; rd_rsp_data SHALL equal ram_rd_data in that cycle; back-to-back reads SHALL sustain one per cycle.
REQ-026 ram_wr_en SHALL be low in any cycle with no issued write; never more than one write per cycle.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, clear pointer/counter, and drive ram_wr_en, ram_wr_addr, ram_wr_data, rd_rsp_valid, clr_busy, clr_done to 0.
REQ-028 Reset during CLEAR SHALL abort the clear with no clr_done pulse; remaining addresses keep prior contents.
REQ-029 After rst_n rises, wr_ready SHALL be high in the first cycle.

Structure
REQ-030 Package osd_ram_pkg SHALL hold ADDR_W/DATA_W defaults, depth constant, and the FSM state type.
REQ-031 Clear pointer/counter/FSM SHALL be one sub-module osd_clr_engine; write-port mux, collision check and read pipeline stay in osd_ram_ctrl.

Verification
REQ-032 Host write 0x5A to 0x123, then read 0x123 two cycles later -> ram_wr_en at N+1, rd_rsp_data = 0x5A one cycle after read accept.
REQ-033 Clear base 0x7FE, len 4, value 0x20 -> writes to 0x7FE,0x7FF,0x000,0x001 in consecutive cycles, clr_done once, wr_ready low throughout.
REQ-034 Clear len 0 and len 4095 -> first: no writes/no done; second: exactly 2048 writes.
REQ-035 Write to 0x010 accepted, read 0x010 requested next cycle -> rd_ready low for that cycle, read accepted the following cycle returning new data.
REQ-036 Same-cycle clr_start and host write to 0x005 -> host write in N+1, fill writes from N+2.
REQ-037 rst_n low at fill write 3 of 10 -> all outputs 0 immediately, no clr_done, addresses 3..9 unchanged.
